token_embedder: RTL and testbench

Downstream stage of the tokenizer encoder in the tensor core front end. Once the encoder has filled its output token buffer, this block walks the buffer and looks up each token ID in an embedding ROM. It streams each embedding vector element by element over a valid/ready interface to the tensor datapath. It uses the same `cs` start/stop style and memory-address conventions as the encoder.

---
 rtl/encoder_pkg.sv | 22 ++
 rtl/token_embedder.sv | 134 +++++++++++++
 tb/tb_token_embedder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Types and helpers shared by the tokenizer encoder and its embedding stage.
package encoder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TOK_RD,
    TOK_CAP,
    EMB_RD,
    EMB_CAP,
    SEND,
    DONE
  } emb_state_t;

  // Embedding ROM address is {token id, element index}.
  function automatic int unsigned emb_addr_width(input int unsigned addr_width,
                                                 input int unsigned emb_dim);
    return addr_width + $clog2(emb_dim);
  endfunction

  localparam int unsigned DEF_EMB_ADDR_WIDTH = emb_addr_width(4, 4);

endpackage

// File: rtl/token_embedder.sv
// Walks the encoder token buffer, looks each token up in the embedding ROM and
// streams the vector elements over valid/ready.
module token_embedder
  import encoder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned EMB_DIM    = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          cs,
  input  logic [ADDR_WIDTH:0]                           n_tok,
  output logic [ADDR_WIDTH-1:0]                         tok_addr,
  input  logic [ADDR_WIDTH-1:0]                         tok_data,
  output logic [emb_addr_width(ADDR_WIDTH, EMB_DIM)-1:0] emb_addr,
  input  logic [DATA_WIDTH-1:0]                         emb_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [DATA_WIDTH-1:0]                         out_data,
  output logic                                          out_last,
  output logic                                          out_eos,
  output logic                                          busy,
  output logic                                          done
);

  localparam int unsigned DIM_WIDTH = $clog2(EMB_DIM);
  localparam int unsigned IDX_WIDTH = ADDR_WIDTH + 1;

  emb_state_t state, state_nxt;

  logic [IDX_WIDTH-1:0]  tok_idx;
  logic [IDX_WIDTH-1:0]  n_reg;
  logic [DIM_WIDTH-1:0]  dim;
  logic [ADDR_WIDTH-1:0] tok_reg;

  logic dim_last, tok_last;
  logic start, cap_tok, load_out, adv_dim, adv_tok, clr_valid;
  logic busy_nxt, done_nxt;

  assign dim_last = (dim == DIM_WIDTH'(EMB_DIM - 1));
  assign tok_last = (tok_idx == n_reg - IDX_WIDTH'(1));

  assign tok_addr = tok_idx[ADDR_WIDTH-1:0];
  assign emb_addr = {tok_reg, dim};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cs) state_nxt = (n_tok != '0) ? TOK_RD : DONE;
      TOK_RD:  state_nxt = TOK_CAP;
      TOK_CAP: state_nxt = EMB_RD;
      EMB_RD:  state_nxt = EMB_CAP;
      EMB_CAP: state_nxt = SEND;
      SEND: begin
        if (out_ready) begin
          if (!dim_last)      state_nxt = EMB_RD;
          else if (!tok_last) state_nxt = TOK_RD;
          else                state_nxt = DONE;
        end
      end
      DONE:    if (!cs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath strobes and next values of the registered status flags.
  always_comb begin
    start     = 1'b0;
    cap_tok   = 1'b0;
    load_out  = 1'b0;
    adv_dim   = 1'b0;
    adv_tok   = 1'b0;
    clr_valid = 1'b0;
    unique case (state)
      IDLE:    start    = cs && (n_tok != '0);
      TOK_CAP: cap_tok  = 1'b1;
      EMB_CAP: load_out = 1'b1;
      SEND: begin
        clr_valid = out_ready;
        adv_dim   = out_ready && !dim_last;
        adv_tok   = out_ready && dim_last && !tok_last;
      end
      default: ;
    endcase
    busy_nxt = (state_nxt != IDLE) && (state_nxt != DONE);
    done_nxt = (state_nxt == DONE);
  end

  // Counters, token capture and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_idx   <= '0;
      n_reg     <= '0;
      dim       <= '0;
      tok_reg   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_eos   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (start) begin
        n_reg   <= n_tok;
        tok_idx <= '0;
        dim     <= '0;
      end
      if (cap_tok) tok_reg <= tok_data;
      if (load_out) begin
        out_data  <= emb_data;
        out_last  <= dim_last;
        out_eos   <= dim_last && tok_last;
        out_valid <= 1'b1;
      end
      if (clr_valid) out_valid <= 1'b0;
      if (adv_dim) dim <= dim + DIM_WIDTH'(1);
      if (adv_tok) begin
        dim     <= '0;
        tok_idx <= tok_idx + IDX_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_token_embedder.sv
// Self-checking bench for token_embedder: table of runs plus reset and rearm
// sequences, scored against a queue of elements built from buffer and ROM.
module tb_token_embedder;

  localparam int unsigned AW       = 4;
  localparam int unsigned DW       = 8;
  localparam int unsigned ED       = 4;
  localparam int unsigned EAW      = AW + $clog2(ED);
  localparam int unsigned NTOK_MAX = 1 << AW;
  localparam int          MAX_K    = 3000;

  // fill: 0 = buffer {3,5,...} with ROM word = address, 1 = random contents.
  // mode: 0 = ready always high, 1 = random ready, 2 = 5-cycle stall on element 2.
  typedef struct {
    int n;
    int fill;
    int mode;
    int exp_edges;
    int exp_first;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          eos;
  } elem_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cs;
  logic [AW:0]    n_tok;
  logic [AW-1:0]  tok_addr;
  logic [AW-1:0]  tok_data;
  logic [EAW-1:0] emb_addr;
  logic [DW-1:0]  emb_data;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic           out_last;
  logic           out_eos;
  logic           busy;
  logic           done;

  logic [AW-1:0] tok_mem [NTOK_MAX];
  logic [DW-1:0] rom [1 << EAW];
  elem_t         exp_q [$];
  int            tests = 0;
  int            fails = 0;

  token_embedder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .EMB_DIM(ED)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .n_tok(n_tok),
    .tok_addr(tok_addr), .tok_data(tok_data),
    .emb_addr(emb_addr), .emb_data(emb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_eos(out_eos), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // External token buffer and ROM, both with one-cycle synchronous reads.
  always @(posedge clk) begin
    tok_data <= tok_mem[tok_addr];
    emb_data <= rom[emb_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_mem(input int fill);
    for (int a = 0; a < int'(NTOK_MAX); a++) tok_mem[a] = AW'($urandom);
    for (int a = 0; a < (1 << EAW); a++) rom[a] = (fill == 0) ? DW'(a) : DW'($urandom);
    if (fill == 0) begin
      tok_mem[0] = AW'(3);
      tok_mem[1] = AW'(5);
    end
  endtask

  // One run from IDLE; k counts negedges after the start edge.
  task automatic run(input string tag, input int n, input int mode, input int exp_edges,
                     input int exp_first, input bit release_cs);
    int k, first_k, got, stall, max_addr;
    bit hold;
    logic [DW-1:0] held;
    elem_t e, x;
    exp_q.delete();
    for (int t = 0; t < n; t++) begin
      for (int d = 0; d < int'(ED); d++) begin
        e.data = rom[int'(tok_mem[t]) * int'(ED) + d];
        e.last = (d == int'(ED) - 1);
        e.eos  = e.last && (t == n - 1);
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    n_tok = (AW+1)'(n);
    cs = 1'b1;
    out_ready = (mode == 0);
    k = 0; first_k = -1; got = 0; stall = 0; max_addr = 0; hold = 1'b0; held = '0;
    do begin
      @(negedge clk);
      k++;
      n_tok = (AW+1)'($urandom_range(0, NTOK_MAX));
      if (mode == 1 && k == 3) cs = 1'b0;
      if (busy && int'(tok_addr) > max_addr) max_addr = int'(tok_addr);
      if (out_valid && first_k < 0) first_k = k;
      if (hold) begin
        check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, " hold_data"}, 32'(out_data), 32'(held));
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (out_valid && got == 1 && stall < 5) begin
            out_ready = 1'b0;
            stall++;
          end else out_ready = 1'b1;
        end
      endcase
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check({tag, " extra_elem"}, 32'(got + 1), 32'(n * int'(ED)));
        else begin
          x = exp_q.pop_front();
          check({tag, " data"}, 32'(out_data), 32'(x.data));
          check({tag, " last"}, 32'(out_last), 32'(x.last));
          check({tag, " eos"}, 32'(out_eos), 32'(x.eos));
        end
        got++;
      end
      hold = out_valid && !out_ready;
      held = out_data;
    end while (!done && k < MAX_K);
    check({tag, " done_reached"}, 32'(done), 32'd1);
    check({tag, " elem_count"}, 32'(got), 32'(n * int'(ED)));
    check({tag, " first_valid"}, 32'(first_k), 32'(exp_first));
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    if (exp_edges != 0) check({tag, " run_length"}, 32'(k), 32'(exp_edges));
    if (n > 0) check({tag, " last_tok_addr"}, 32'(max_addr), 32'(n - 1));
    out_ready = 1'b0;
    if (release_cs) begin
      cs = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check({tag, " back_to_idle"}, 32'({busy, done}), 32'd0);
    end
  endtask

  vec_t vecs [$];

  initial begin
    int cnt, waited;
    bit seen;
    vecs.push_back('{n: 2,  fill: 0, mode: 0, exp_edges: 29,  exp_first: 5});
    vecs.push_back('{n: 2,  fill: 0, mode: 2, exp_edges: 34,  exp_first: 5});
    vecs.push_back('{n: 0,  fill: 0, mode: 0, exp_edges: 1,   exp_first: -1});
    vecs.push_back('{n: 16, fill: 1, mode: 0, exp_edges: 225, exp_first: 5});
    vecs.push_back('{n: 1,  fill: 1, mode: 0, exp_edges: 15,  exp_first: 5});
    vecs.push_back('{n: 5,  fill: 1, mode: 1, exp_edges: 0,   exp_first: 5});
    vecs.push_back('{n: 16, fill: 1, mode: 1, exp_edges: 0,   exp_first: 5});

    rst_n = 1'b0; cs = 1'b0; n_tok = '0; out_ready = 1'b0;
    load_mem(0);
    repeat (2) @(negedge clk);
    check("reset outputs", 32'({out_valid, out_last, out_eos, busy, done}), 32'd0);
    check("reset addr", 32'({tok_addr, emb_addr, out_data}), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      load_mem(vecs[i].fill);
      run($sformatf("vec%0d", i), vecs[i].n, vecs[i].mode, vecs[i].exp_edges,
          vecs[i].exp_first, 1'b1);
    end

    for (int r = 0; r < 6; r++) begin
      cnt = $urandom_range(1, NTOK_MAX);
      load_mem(1);
      run($sformatf("rand%0d", r), cnt, 1, 0, 5, 1'b1);
    end

    // Reset asserted while an element is waiting in SEND.
    load_mem(0);
    @(negedge clk);
    n_tok = (AW+1)'(2); cs = 1'b1; out_ready = 1'b0;
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("rst wait_send", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst mid_send flags", 32'({out_valid, busy, done}), 32'd0);
    check("rst mid_send addr", 32'({tok_addr, emb_addr}), 32'd0);
    cs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      seen |= out_valid | busy | done;
    end
    check("rst quiet_after", 32'(seen), 32'd0);
    out_ready = 1'b0;

    // Holding cs after completion must not restart; a fresh cs edge does.
    load_mem(0);
    run("rearm1", 2, 0, 29, 5, 1'b0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (done && !busy && !out_valid) cnt++;
    end
    check("rearm hold_done", 32'(cnt), 32'd5);
    cs = 1'b0;
    @(negedge clk);
    check("rearm to_idle", 32'(done), 32'd0);
    run("rearm2", 2, 0, 29, 5, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
